// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer slice.
// Contents: playback FSM state enum, default instruction width, and the NOP
// encoding driven on the instruction bus whenever nothing valid is presented.
package instr_seq_pkg;

  localparam int IW_DEFAULT = 4;

  localparam logic [IW_DEFAULT-1:0] NOP_INSTR = 4'b0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_STEP = 2'd2,
    FINISH    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/instr_buffer.sv
// Program store for the instruction sequencer.
// DEPTH x IW register array with one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset: its contents
// only matter below prog_len, which is reset in the top.
// Ports:
//   clk    in  1   rising-edge clock
//   we     in  1   write enable
//   waddr  in  AW  write index
//   wdata  in  IW  write data
//   raddr  in  AW  read index
//   rdata  out IW  combinational read data
module instr_buffer #(
  parameter int IW    = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_r [DEPTH];

  // Synchronous write of one program entry.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Source end of the processor instruction interface. Holds a short program,
// then plays it out one instruction per accepted valid/ready handshake, with
// free-run, single-step, loop and abort control.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_en, load_data    append an instruction (IDLE only)
//   clear                 empty the program and clear overflow (IDLE only)
//   start                 begin playback at pc=0 (IDLE only, non-empty program)
//   step_mode, step_req   single-step control
//   loop_en               wrap to pc=0 after the last instruction
//   abort                 return to IDLE next cycle, no done pulse
//   out_ready             processor accepts the presented instruction
//   instr_valid           instruction output valid
//   instruction           buf[pc] while valid, NOP_INSTR otherwise
//   pc                    index of the presented instruction
//   prog_len              number of stored instructions (0..DEPTH)
//   busy                  state != IDLE
//   done                  one-cycle pulse when a non-loop run completes
//   overflow              sticky: load attempted while full
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int IW    = IW_DEFAULT,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [IW-1:0] load_data,
  input  logic          clear,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step_req,
  input  logic          loop_en,
  input  logic          abort,
  input  logic          out_ready,
  output logic          instr_valid,
  output logic [IW-1:0] instruction,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_len,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);

  seq_state_e    state_r, state_s;
  logic [AW-1:0] pc_r, pc_s;
  logic [AW:0]   len_r, len_s;
  logic          ovf_r, ovf_s;
  logic          we_s;
  logic          last_s;
  logic [IW-1:0] rd_data_s;

  instr_buffer #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (we_s),
    .waddr (len_r[AW-1:0]),
    .wdata (load_data),
    .raddr (pc_r),
    .rdata (rd_data_s)
  );

  // pc is presenting the final stored instruction (len_r >= 1 whenever this matters).
  assign last_s = ({1'b0, pc_r} == (len_r - (AW + 1)'(1)));

  // Next-state, pc, program length and overflow decode.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    len_s   = len_r;
    ovf_s   = ovf_r;
    we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear) begin
          len_s = '0;
          ovf_s = 1'b0;
        end else if (load_en) begin
          if (len_r < FULL_LEN) begin
            we_s  = 1'b1;
            len_s = len_r + (AW + 1)'(1);
          end else begin
            ovf_s = 1'b1;
          end
        end else begin
          len_s = len_r;
        end
        if (start && (len_r != '0)) begin
          pc_s    = '0;
          state_s = step_mode ? WAIT_STEP : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // abort wins over a same-cycle handshake; that beat is still consumed
        // by the processor, the sequencer simply does not advance past it.
        if (abort) begin
          pc_s    = '0;
          state_s = IDLE;
        end else if (out_ready) begin
          if (last_s && !loop_en) begin
            state_s = FINISH;
          end else begin
            pc_s    = last_s ? '0 : (pc_r + AW'(1));
            state_s = step_mode ? WAIT_STEP : RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      WAIT_STEP: begin
        if (abort) begin
          pc_s    = '0;
          state_s = IDLE;
        end else if (step_req || !step_mode) begin
          state_s = RUN;
        end else begin
          state_s = WAIT_STEP;
        end
      end
      FINISH: begin
        pc_s    = '0;
        state_s = IDLE;
      end
      default: begin
        pc_s    = '0;
        state_s = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= '0;
      len_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      len_r   <= len_s;
      ovf_r   <= ovf_s;
    end
  end

  // Outputs are pure decodes of registered state so an asynchronous reset
  // clears them immediately.
  assign instr_valid = (state_r == RUN);
  assign instruction = instr_valid ? rd_data_s : IW'(NOP_INSTR);
  assign pc          = pc_r;
  assign prog_len    = len_r;
  assign busy        = (state_r != IDLE);
  assign done        = (state_r == FINISH);
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Expected values come from a
// program queue (what was loaded) and the index of the next instruction the
// processor should receive.
module tb_instr_sequencer;

  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step_req = 1'b0;
  logic          loop_en = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          instr_valid;
  logic [IW-1:0] instruction;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0] prog_q[$];
  bit            model_ovf = 1'b0;

  instr_sequencer #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_data   (load_data),
    .clear       (clear),
    .start       (start),
    .step_mode   (step_mode),
    .step_req    (step_req),
    .loop_en     (loop_en),
    .abort       (abort),
    .out_ready   (out_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc),
    .prog_len    (prog_len),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [IW-1:0] d);
    load_en   = 1'b1;
    load_data = d;
    tick();
    load_en = 1'b0;
    if (prog_q.size() < DEPTH) prog_q.push_back(d);
    else model_ovf = 1'b1;
  endtask

  task automatic clear_prog();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if ({instr_valid, instruction, pc, prog_len, busy, done, overflow} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b i=%h pc=%0d len=%0d busy=%b done=%b ovf=%b, want all zero",
               instr_valid, instruction, pc, prog_len, busy, done, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_prog();
    load_one(4'h3);
    load_one(4'h5);
    load_one(4'h9);
    n_checks++;
    if (prog_len !== 5'(prog_q.size()) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_load: len=%0d busy=%b, want len=%0d busy=0", prog_len, busy, prog_q.size());
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < prog_q.size(); k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instruction !== prog_q[k] || pc !== AW'(k)) begin
        n_fail++;
        $display("FAIL basic_play[%0d]: v=%b i=%h pc=%0d, want v=1 i=%h pc=%0d",
                 k, instr_valid, instruction, pc, prog_q[k], k);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || instr_valid !== 1'b0 || instruction !== 4'h0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b v=%b i=%h, want done=1 v=0 i=0", done, instr_valid, instruction);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pc !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_idle: done=%b busy=%b pc=%0d, want 0 0 0", done, busy, pc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [4:0] pat;
    int k;
    pat = 5'b11001;
    k = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      out_ready = pat[c];
      n_checks++;
      if (instr_valid !== 1'b1 || instruction !== prog_q[k] || pc !== AW'(k)) begin
        n_fail++;
        $display("FAIL stall[%0d]: v=%b i=%h pc=%0d, want v=1 i=%h pc=%0d",
                 c, instr_valid, instruction, pc, prog_q[k], k);
      end
      if (pat[c]) k++;
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done: done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int len;
      int k;
      int cyc;
      clear_prog();
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) load_one(IW'($urandom));
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      cyc = 0;
      while (k < len && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== prog_q[k] || pc !== AW'(k)) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: v=%b i=%h pc=%0d, want v=1 i=%h pc=%0d",
                   r, cyc, instr_valid, instruction, pc, prog_q[k], k);
        end
        if (out_ready) k++;
        tick();
        cyc++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (k < len || done !== 1'b1) begin
        n_fail++;
        $display("FAIL random_done[%0d]: accepted=%0d done=%b, want accepted=%0d done=1", r, k, done, len);
      end
      tick();
    end
  endtask

  task automatic test_loop();
    logic [IW-1:0] d;
    clear_prog();
    load_one(4'hA);
    load_one(4'hB);
    loop_en = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instruction !== prog_q[k % 2] || pc !== AW'(k % 2) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL loop[%0d]: v=%b i=%h pc=%0d done=%b, want v=1 i=%h pc=%0d done=0",
                 k, instr_valid, instruction, pc, done, prog_q[k % 2], k % 2);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || pc !== 4'd0 || instr_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_abort: busy=%b pc=%0d v=%b done=%b, want all 0", busy, pc, instr_valid, done);
    end
    clear_prog();
    d = IW'($urandom);
    load_one(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instruction !== d || pc !== 4'd0) begin
        n_fail++;
        $display("FAIL loop_single[%0d]: v=%b i=%h pc=%0d, want v=1 i=%h pc=0", k, instr_valid, instruction, pc, d);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loop_en = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_step();
    clear_prog();
    for (int i = 0; i < 3; i++) load_one(IW'($urandom));
    step_mode = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 2; w++) begin
        n_checks++;
        if (instr_valid !== 1'b0 || busy !== 1'b1 || pc !== AW'(k)) begin
          n_fail++;
          $display("FAIL step_wait[%0d.%0d]: v=%b busy=%b pc=%0d, want v=0 busy=1 pc=%0d",
                   k, w, instr_valid, busy, pc, k);
        end
        tick();
      end
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b1 || instruction !== prog_q[k] || pc !== AW'(k)) begin
        n_fail++;
        $display("FAIL step_issue[%0d]: v=%b i=%h pc=%0d, want v=1 i=%h pc=%0d",
                 k, instr_valid, instruction, pc, prog_q[k], k);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL step_done: done=%b v=%b, want done=1 v=0", done, instr_valid);
    end
    tick();
    step_mode = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    clear_prog();
    for (int i = 0; i < DEPTH + 1; i++) load_one(IW'($urandom));
    n_checks++;
    if (prog_len !== 5'(prog_q.size()) || overflow !== model_ovf) begin
      n_fail++;
      $display("FAIL overflow_full: len=%0d ovf=%b, want len=%0d ovf=%b", prog_len, overflow, prog_q.size(), model_ovf);
    end
    clear_prog();
    n_checks++;
    if (prog_len !== 5'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: len=%0d ovf=%b, want 0 0", prog_len, overflow);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_start: busy=%b v=%b, want 0 0", busy, instr_valid);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_start_hold: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    clear_prog();
    load_one(4'h7);
    load_one(4'hC);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || pc !== 4'd1 || instruction !== prog_q[1]) begin
      n_fail++;
      $display("FAIL arst_pre: v=%b pc=%0d i=%h, want v=1 pc=1 i=%h", instr_valid, pc, instruction, prog_q[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instruction !== 4'h0 || pc !== 4'd0 || busy !== 1'b0 ||
        done !== 1'b0 || prog_len !== 5'd0) begin
      n_fail++;
      $display("FAIL arst_mid: v=%b i=%h pc=%0d busy=%b done=%b len=%0d, want all 0",
               instr_valid, instruction, pc, busy, done, prog_len);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    prog_q.delete();
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_after: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_loop();
    test_step();
    test_overflow();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
